prm_edge_scan_ctrl: RTL and testbench

//  Sequencer for the bank of combinational PRM edge-obstacle checkers (15-bit sample -> per-edge mask).

---
 rtl/prm_pkg.sv | 14 +
 rtl/prm_edge_scan_ctrl_if.sv | 33 +++
 rtl/prm_lat_pipe.sv | 29 ++
 rtl/prm_edge_scan_ctrl.sv | 93 +++++++++
 tb/tb_prm_edge_scan_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/prm_pkg.sv
// rtl/prm_pkg.sv - shared types and constants for the PRM edge-scan controller
package prm_pkg;

  localparam int PRM_IN_W      = 15;
  localparam int PRM_NUM_EDGES = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/prm_edge_scan_ctrl_if.sv
// rtl/prm_edge_scan_ctrl_if.sv - sample, checker-bank and result signals of the edge-scan controller
interface prm_edge_scan_ctrl_if
  import prm_pkg::*;
#(
  parameter int IN_W      = PRM_IN_W,
  parameter int NUM_EDGES = PRM_NUM_EDGES,
  parameter int CNT_W     = 8
);
  logic                 start;
  logic [CNT_W-1:0]     pt_count;
  logic                 abort;
  logic                 pt_valid;
  logic                 pt_ready;
  logic [IN_W-1:0]      pt_data;
  logic [IN_W-1:0]      chk_vec;
  logic                 chk_vec_valid;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 res_valid;
  logic                 res_ready;
  logic [NUM_EDGES-1:0] res_mask;
  logic                 res_any;
  logic                 busy;

  // master is the controller, slave is the surrounding sample source / bank / planner
  modport master (
    input  start, pt_count, abort, pt_valid, pt_data, chk_mask, res_ready,
    output pt_ready, chk_vec, chk_vec_valid, res_valid, res_mask, res_any, busy
  );
  modport slave (
    output start, pt_count, abort, pt_valid, pt_data, chk_mask, res_ready,
    input  pt_ready, chk_vec, chk_vec_valid, res_valid, res_mask, res_any, busy
  );
endinterface

// File: rtl/prm_lat_pipe.sv
// rtl/prm_lat_pipe.sv - valid shift register matching the checker-bank latency
module prm_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in,
  output logic head,
  output logic tail,
  output logic any
);
  logic [DEPTH-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= in;
      for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
    end
  end

  assign head = v[0];
  assign tail = v[DEPTH-1];
  assign any  = |v;
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// rtl/prm_edge_scan_ctrl.sv - feeds a sample burst to the edge-checker bank and ORs the blocked-edge masks
module prm_edge_scan_ctrl
  import prm_pkg::*;
#(
  parameter int IN_W      = PRM_IN_W,
  parameter int NUM_EDGES = PRM_NUM_EDGES,
  parameter int CNT_W     = 8,
  parameter int CHK_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prm_edge_scan_ctrl_if.master bus
);
  scan_state_t          state, state_nx;
  logic [CNT_W-1:0]     remaining;
  logic [NUM_EDGES-1:0] acc;
  logic [IN_W-1:0]      chk_vec;
  logic                 pt_ready, res_valid, busy;
  logic                 accept, head, tail, inflight;

  assign accept = bus.pt_valid & pt_ready & ~bus.abort;

  // stage 0 of the pipe is chk_vec_valid itself; the tail lines up with the bank's mask
  prm_lat_pipe #(.DEPTH(CHK_LAT)) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.abort),
    .in    (accept),
    .head  (head),
    .tail  (tail),
    .any   (inflight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_nx = (bus.pt_count != '0) ? S_SCAN : S_DONE;
        S_SCAN:  if (accept && remaining == CNT_W'(1)) state_nx = S_DRAIN;
        S_DRAIN: if (!inflight) state_nx = S_DONE;
        S_DONE:  if (bus.res_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pt_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:  busy      = 1'b0;
      S_SCAN:  pt_ready  = (remaining != '0);
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      acc       <= '0;
      chk_vec   <= '0;
    end else if (bus.abort) begin
      remaining <= '0;
      acc       <= '0;
    end else if (state == S_IDLE && bus.start) begin
      remaining <= bus.pt_count;
      acc       <= '0;
    end else begin
      if (accept) begin
        chk_vec   <= bus.pt_data;
        remaining <= remaining - CNT_W'(1);
      end
      if (tail) acc <= acc | bus.chk_mask;
    end
  end

  assign bus.pt_ready      = pt_ready;
  assign bus.chk_vec       = chk_vec;
  assign bus.chk_vec_valid = head;
  assign bus.res_valid     = res_valid;
  assign bus.res_mask      = acc;
  assign bus.res_any       = |acc;
  assign bus.busy          = busy;
endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// tb/tb_prm_edge_scan_ctrl.sv - directed scoreboard bench running a 1-cycle and a 3-cycle bank side by side
module tb_prm_edge_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, abort, pt_valid, res_ready;
  logic [7:0]  pt_count;
  logic [14:0] pt_data;

  int errs = 0;
  int checks = 0;
  int cv1 = 0, cv3 = 0, unexp1 = 0, unexp3 = 0;
  int lat1, lat3, c1, c3;
  logic [63:0] q1[$], q3[$];
  logic [63:0] e1, e3, m4;
  logic [14:0] samp[$];

  always #5 clk = ~clk;

  prm_edge_scan_ctrl_if #(.IN_W(15), .NUM_EDGES(64), .CNT_W(8)) if1 ();
  prm_edge_scan_ctrl_if #(.IN_W(15), .NUM_EDGES(64), .CNT_W(8)) if3 ();

  assign if1.start = start;       assign if3.start = start;
  assign if1.pt_count = pt_count; assign if3.pt_count = pt_count;
  assign if1.abort = abort;       assign if3.abort = abort;
  assign if1.pt_valid = pt_valid; assign if3.pt_valid = pt_valid;
  assign if1.pt_data = pt_data;   assign if3.pt_data = pt_data;
  assign if1.res_ready = res_ready; assign if3.res_ready = res_ready;

  // bank stubs: mask = sample zero-extended; all-ones garbage whenever no live sample is presented
  logic [14:0] m3a = '0, m3b = '0;
  logic        v3a = 1'b0, v3b = 1'b0;
  always @(posedge clk) begin
    m3a <= if3.chk_vec; m3b <= m3a;
    v3a <= if3.chk_vec_valid; v3b <= v3a;
  end
  assign if1.chk_mask = if1.chk_vec_valid ? {49'b0, if1.chk_vec} : '1;
  assign if3.chk_mask = v3b ? {49'b0, m3b} : '1;

  prm_edge_scan_ctrl #(.IN_W(15), .NUM_EDGES(64), .CNT_W(8), .CHK_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  prm_edge_scan_ctrl #(.IN_W(15), .NUM_EDGES(64), .CNT_W(8), .CHK_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl_l1"}, {if1.busy, if1.res_valid, if1.pt_ready, if1.chk_vec_valid, if1.res_any}, 0);
    chk({tag, "_ctl_l3"}, {if3.busy, if3.res_valid, if3.pt_ready, if3.chk_vec_valid, if3.res_any}, 0);
    chk({tag, "_vec_l1"}, if1.chk_vec, 0);
    chk({tag, "_vec_l3"}, if3.chk_vec, 0);
    chk({tag, "_mask_l1"}, if1.res_mask, 0);
    chk({tag, "_mask_l3"}, if3.res_mask, 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && (if1.busy || if3.busy); k++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {if1.busy, if3.busy}, 0);
    chk({tag, "_sb_left"}, q1.size() + q3.size(), 0);
    chk({tag, "_sb_unexpected"}, unexp1 + unexp3, 0);
  endtask

  task automatic burst(input int n, input bit gaps);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m = m | {49'b0, samp[i]};
    q1.push_back(m);
    q3.push_back(m);
    start = 1'b1; pt_count = 8'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      pt_valid = 1'b1; pt_data = samp[i];
      @(negedge clk);
      chk("pt_ready_l1", if1.pt_ready, 1);
      chk("pt_ready_l3", if3.pt_ready, 1);
      step();
      pt_valid = 1'b0;
      if (gaps) step();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if1.chk_vec_valid) cv1++;
      if (if3.chk_vec_valid) cv3++;
      if (if1.res_valid && res_ready) begin
        if (q1.size() == 0) unexp1++;
        else begin
          e1 = q1.pop_front();
          chk("res_mask_l1", if1.res_mask, e1);
          chk("res_any_l1", 64'(if1.res_any), 64'(|e1));
        end
      end
      if (if3.res_valid && res_ready) begin
        if (q3.size() == 0) unexp3++;
        else begin
          e3 = q3.pop_front();
          chk("res_mask_l3", if3.res_mask, e3);
          chk("res_any_l3", 64'(if3.res_any), 64'(|e3));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; abort = 1'b0; pt_valid = 1'b0; res_ready = 1'b0;
    pt_count = '0; pt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // T1: three back-to-back samples, result latency per bank depth
    res_ready = 1'b1;
    samp = '{15'h0001, 15'h4200, 15'h7FFF};
    burst(3, 1'b0);
    lat1 = 0; lat3 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t1_ready_off_l1", if1.pt_ready, 0);
        chk("t1_ready_off_l3", if3.pt_ready, 0);
      end
      if (lat1 != 0 && k == lat1 + 2) chk("t1_valid_drop_l1", if1.res_valid, 0);
      if (lat1 == 0 && if1.res_valid) lat1 = k - 1;
      if (lat3 == 0 && if3.res_valid) lat3 = k - 1;
    end
    chk("t1_latency_l1", lat1, 2);
    chk("t1_latency_l3", lat3, 4);
    wait_idle("t1");

    // T2: empty burst gives an immediate all-clear result
    samp = {};
    burst(0, 1'b0);
    @(negedge clk);
    chk("t2_valid", {if1.res_valid, if3.res_valid}, 2'b11);
    chk("t2_pt_ready", {if1.pt_ready, if3.pt_ready}, 0);
    step();
    @(negedge clk);
    chk("t2_valid_drop", {if1.res_valid, if3.res_valid}, 0);
    wait_idle("t2");

    // T3: pt_valid toggling, every sample must be accumulated exactly once
    samp = '{15'h0011, 15'h0220, 15'h4400, 15'h0008};
    c1 = cv1; c3 = cv3;
    burst(4, 1'b1);
    wait_idle("t3");
    chk("t3_accepts_l1", cv1 - c1, 4);
    chk("t3_accepts_l3", cv3 - c3, 4);

    // T4: result held while planner stalls; start during DONE ignored
    res_ready = 1'b0;
    samp = '{15'h0101, 15'h1010};
    m4 = {49'b0, samp[0] | samp[1]};
    burst(2, 1'b0);
    for (int k = 0; k < 20 && !(if1.res_valid && if3.res_valid); k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", {if1.res_valid, if3.res_valid}, 2'b11);
      chk("t4_hold_mask_l1", if1.res_mask, m4);
      chk("t4_hold_mask_l3", if3.res_mask, m4);
      if (k == 4) begin start = 1'b1; pt_count = 8'd0; end
      if (k == 5) start = 1'b0;
    end
    step();
    res_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t4_release_idle", {if1.busy, if3.busy, if1.res_valid, if3.res_valid}, 0);
    wait_idle("t4");

    // T5: abort after two of five samples, then an immediate one-sample scan
    start = 1'b1; pt_count = 8'd5;
    step();
    start = 1'b0; pt_valid = 1'b1; pt_data = 15'h0F00;
    step();
    pt_data = 15'h00F0;
    step();
    pt_data = 15'h7000; abort = 1'b1;
    step();
    abort = 1'b0; pt_valid = 1'b0;
    @(negedge clk);
    chk("t5_abort_l1", {if1.busy, if1.res_valid, if1.chk_vec_valid}, 0);
    chk("t5_abort_l3", {if3.busy, if3.res_valid, if3.chk_vec_valid}, 0);
    samp = '{15'h0100};
    burst(1, 1'b0);
    wait_idle("t5");

    // T6: asynchronous reset in DRAIN, then a clean two-sample scan
    start = 1'b1; pt_count = 8'd2;
    step();
    start = 1'b0; pt_valid = 1'b1; pt_data = 15'h5555;
    step();
    pt_data = 15'h2AAA;
    step();
    pt_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_drain", {if1.busy, if3.busy, if1.pt_ready, if3.pt_ready}, 4'b1100);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_rst");
    step();
    rst_n = 1'b1;
    step();
    samp = '{15'h0003, 15'h0C00};
    burst(2, 1'b0);
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
